// File: rtl/fp_div_seq_if.sv
// Start/done handshake bundle between the ALU and the sequential FP divider.
interface fp_div_seq_if;
    logic        start;
    logic [31:0] fp_X;
    logic [31:0] fp_Y;
    logic [2:0]  r_mode;
    logic        busy;
    logic        done;
    logic [31:0] fp_Z;
    logic        ovrf;
    logic        udrf;
    logic        zer;
    logic        inf;
    logic        nan;

    modport master (
        output start, fp_X, fp_Y, r_mode,
        input  busy, done, fp_Z, ovrf, udrf, zer, inf, nan
    );

    modport slave (
        input  start, fp_X, fp_Y, r_mode,
        output busy, done, fp_Z, ovrf, udrf, zer, inf, nan
    );
endinterface

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider, radix-2 restoring, one quotient bit per clock.
// Subnormals are flushed to zero on input and output.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | 26 restoring iterations, cnt_q 0..25
// RND   | round, exponent range check, load result
// DONE  | done pulse; start accepted again here
module fp_div_seq #(
    parameter logic [7:0]  BIAS = 8'd127,
    parameter logic [31:0] QNAN = 32'h7FC00000
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_div_seq_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, RND, DONE} state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [24:0]        r_q, r_d;
    logic [24:0]        q_q, q_d;
    logic [23:0]        my_q, my_d;
    logic signed [9:0]  e_q, e_d;
    logic               sign_q, sign_d;
    logic [2:0]         rmode_q, rmode_d;
    logic [31:0]        z_q, z_d;
    logic               ovrf_q, ovrf_d;
    logic               udrf_q, udrf_d;
    logic               zer_q, zer_d;
    logic               inf_q, inf_d;
    logic               nan_q, nan_d;

    // operand classification on the live inputs (evaluated on the start edge)
    logic [7:0]  ex, ey;
    logic [22:0] fx, fy;
    logic        x_zero, x_inf, x_nan, y_zero, y_inf, y_nan;
    logic        spec_nan, spec_inf, spec_zer, special;
    logic        op_sign;

    assign ex      = bus.fp_X[30:23];
    assign ey      = bus.fp_Y[30:23];
    assign fx      = bus.fp_X[22:0];
    assign fy      = bus.fp_Y[22:0];
    assign op_sign = bus.fp_X[31] ^ bus.fp_Y[31];

    assign x_zero = (ex == 8'h00);
    assign y_zero = (ey == 8'h00);
    assign x_inf  = (ex == 8'hFF) && (fx == 23'd0);
    assign y_inf  = (ey == 8'hFF) && (fy == 23'd0);
    assign x_nan  = (ex == 8'hFF) && (fx != 23'd0);
    assign y_nan  = (ey == 8'hFF) && (fy != 23'd0);

    assign spec_nan = x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf);
    assign spec_inf = !spec_nan && (x_inf || y_zero);
    assign spec_zer = !spec_nan && !spec_inf && (x_zero || y_inf);
    assign special  = spec_nan || spec_inf || spec_zer;

    // normal-path setup: pre-shift the dividend so the first quotient bit is always 1
    logic [23:0]       mx, my;
    logic              x_lt;
    logic [24:0]       mx_ext;
    logic signed [9:0] e_init;

    assign mx     = {1'b1, fx};
    assign my     = {1'b1, fy};
    assign x_lt   = (mx < my);
    assign mx_ext = x_lt ? {mx, 1'b0} : {1'b0, mx};
    assign e_init = $signed({2'b00, ex}) - $signed({2'b00, ey})
                  + $signed({2'b00, BIAS}) - (x_lt ? 10'sd1 : 10'sd0);

    logic        accept;
    logic        ge;
    logic [24:0] r_sub;

    assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));
    assign ge     = (r_q >= {1'b0, my_q});
    assign r_sub  = ge ? (r_q - {1'b0, my_q}) : r_q;

    // rounding; q_q drops the always-one leading bit, so q_q = f(23) G R
    logic              g_bit, r_bit, s_bit, lsb, inc;
    logic              carry;
    logic [22:0]       frac_r;
    logic signed [9:0] e_r;

    assign g_bit = q_q[1];
    assign r_bit = q_q[0];
    assign s_bit = |r_q;
    assign lsb   = q_q[2];

    always_comb begin
        inc = 1'b0;
        case (rmode_q)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign_q && (g_bit || r_bit || s_bit);
            3'b011:  inc = !sign_q && (g_bit || r_bit || s_bit);
            3'b100:  inc = g_bit;
            default: inc = g_bit && (r_bit || s_bit || lsb);
        endcase
    end

    assign {carry, frac_r} = {1'b0, q_q[24:2]} + {23'd0, inc};
    assign e_r             = e_q + (carry ? 10'sd1 : 10'sd0);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) state_d = special ? DONE : CALC;
                else        state_d = IDLE;
            end
            CALC:    if (cnt_q == 5'd25) state_d = RND;
            RND:     state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.busy = (state_q == CALC) || (state_q == RND);
        bus.done = (state_q == DONE);
    end

    assign bus.fp_Z = z_q;
    assign bus.ovrf = ovrf_q;
    assign bus.udrf = udrf_q;
    assign bus.zer  = zer_q;
    assign bus.inf  = inf_q;
    assign bus.nan  = nan_q;

    // datapath next-state
    always_comb begin
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        my_d    = my_q;
        e_d     = e_q;
        sign_d  = sign_q;
        rmode_d = rmode_q;
        z_d     = z_q;
        ovrf_d  = ovrf_q;
        udrf_d  = udrf_q;
        zer_d   = zer_q;
        inf_d   = inf_q;
        nan_d   = nan_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    sign_d  = op_sign;
                    rmode_d = bus.r_mode;
                    if (special) begin
                        ovrf_d = 1'b0;
                        udrf_d = 1'b0;
                        nan_d  = spec_nan;
                        inf_d  = spec_inf;
                        zer_d  = spec_zer;
                        if (spec_nan)      z_d = QNAN;
                        else if (spec_inf) z_d = {op_sign, 8'hFF, 23'd0};
                        else               z_d = {op_sign, 31'd0};
                    end else begin
                        r_d   = mx_ext;
                        q_d   = 25'd0;
                        my_d  = my;
                        e_d   = e_init;
                        cnt_d = 5'd0;
                    end
                end
            end
            CALC: begin
                r_d   = r_sub << 1;
                q_d   = {q_q[23:0], ge};
                cnt_d = cnt_q + 5'd1;
            end
            RND: begin
                ovrf_d = 1'b0;
                udrf_d = 1'b0;
                zer_d  = 1'b0;
                inf_d  = 1'b0;
                nan_d  = 1'b0;
                if (e_r >= 10'sd255) begin
                    z_d    = {sign_q, 8'hFF, 23'd0};
                    ovrf_d = 1'b1;
                    inf_d  = 1'b1;
                end else if (e_r <= 10'sd0) begin
                    z_d    = {sign_q, 31'd0};
                    udrf_d = 1'b1;
                    zer_d  = 1'b1;
                end else begin
                    z_d = {sign_q, e_r[7:0], frac_r};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 5'd0;
            r_q     <= 25'd0;
            q_q     <= 25'd0;
            my_q    <= 24'd0;
            e_q     <= 10'sd0;
            sign_q  <= 1'b0;
            rmode_q <= 3'd0;
            z_q     <= 32'd0;
            ovrf_q  <= 1'b0;
            udrf_q  <= 1'b0;
            zer_q   <= 1'b0;
            inf_q   <= 1'b0;
            nan_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            my_q    <= my_d;
            e_q     <= e_d;
            sign_q  <= sign_d;
            rmode_q <= rmode_d;
            z_q     <= z_d;
            ovrf_q  <= ovrf_d;
            udrf_q  <= udrf_d;
            zer_q   <= zer_d;
            inf_q   <= inf_d;
            nan_q   <= nan_d;
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: directed cases with fixed answers plus random ops
// checked against an integer long-division reference model.
module tb_fp_div_seq;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    fp_div_seq_if bus();

    fp_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // flags packed as {ovrf, udrf, zer, inf, nan}
    typedef struct {
        logic [31:0] z;
        logic [4:0]  fl;
        int          lat;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
        exp_t   r;
        logic   s, xz, xi, xn, yz, yi, yn, g, rb, st, inc;
        int     ex, ey, e;
        longint mx, my, num, qq, rem, mant;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 23'd0);
        yi = (ey == 255) && (y[22:0] == 23'd0);
        xn = (ex == 255) && (x[22:0] != 23'd0);
        yn = (ey == 255) && (y[22:0] != 23'd0);
        r.lat = 1;
        r.due = 0;
        r.fl  = 5'b00000;
        if (xn || yn || (xz && yz) || (xi && yi)) begin
            r.z = 32'h7FC00000; r.fl = 5'b00001; return r;
        end
        if (xi || yz) begin
            r.z = {s, 8'hFF, 23'd0}; r.fl = 5'b00010; return r;
        end
        if (xz || yi) begin
            r.z = {s, 31'd0}; r.fl = 5'b00100; return r;
        end
        mx  = longint'({1'b1, x[22:0]});
        my  = longint'({1'b1, y[22:0]});
        num = mx << 26;
        qq  = num / my;
        rem = num % my;
        e   = ex - ey + 127;
        if (qq >= (longint'(1) << 26)) begin
            mant = qq >> 3; g = qq[2]; rb = qq[1]; st = qq[0] || (rem != 0);
        end else begin
            e = e - 1;
            mant = qq >> 2; g = qq[1]; rb = qq[0]; st = (rem != 0);
        end
        case (m)
            3'd1:    inc = 1'b0;
            3'd2:    inc = s && (g || rb || st);
            3'd3:    inc = !s && (g || rb || st);
            3'd4:    inc = g;
            default: inc = g && (rb || st || mant[0]);
        endcase
        if (inc) mant = mant + 1;
        if (mant == (longint'(1) << 24)) begin
            mant = longint'(1) << 23;
            e = e + 1;
        end
        r.lat = 28;
        if (e >= 255) begin
            r.z = {s, 8'hFF, 23'd0}; r.fl = 5'b10010;
        end else if (e <= 0) begin
            r.z = {s, 31'd0}; r.fl = 5'b01100;
        end else begin
            r.z = {s, 8'(e), mant[22:0]};
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // called #1 after a posedge while the DUT is in IDLE or DONE
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                         input logic [31:0] z, input logic [4:0] fl, input int lat);
        exp_t e;
        bus.fp_X   = x;
        bus.fp_Y   = y;
        bus.r_mode = m;
        bus.start  = 1'b1;
        e.z   = z;
        e.fl  = fl;
        e.lat = lat;
        e.due = cyc + lat;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic issue_model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
        exp_t e;
        e = model(x, y, m);
        issue(x, y, m, e.z, e.fl, e.lat);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!bus.done) begin
            failures++;
            $display("FAIL done_timeout waited=%0d cycles required=done", n);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        int          k;
        k = $urandom_range(0, 19);
        v[31]   = 1'($urandom_range(0, 1));
        v[22:0] = 23'($urandom);
        case (k)
            0:       v[30:23] = 8'h00;
            1:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            2:       v[30:23] = 8'hFF;
            3:       v[30:23] = ($urandom_range(0, 1) != 0) ? 8'd1 : 8'd254;
            4:       v[30:23] = 8'($urandom_range(1, 254));
            default: v[30:23] = 8'($urandom_range(64, 190));
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done fp_Z=%h required=no_done", bus.fp_Z);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.fp_Z !== mon_e.z
                    || {bus.ovrf, bus.udrf, bus.zer, bus.inf, bus.nan} !== mon_e.fl
                    || cyc != mon_e.due) begin
                    failures++;
                    $display("FAIL result fp_Z=%h flags=%b cycle=%0d required fp_Z=%h flags=%b cycle=%0d",
                             bus.fp_Z, {bus.ovrf, bus.udrf, bus.zer, bus.inf, bus.nan}, cyc,
                             mon_e.z, mon_e.fl, mon_e.due);
                end
            end
        end
    end

    initial begin
        logic [31:0] x, y;
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.fp_X   = 32'd0;
        bus.fp_Y   = 32'd0;
        bus.r_mode = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_fp_Z", bus.fp_Z, 32'd0);
        check("reset_done_busy", {30'd0, bus.done, bus.busy}, 32'd0);
        check("reset_flags", {27'd0, bus.ovrf, bus.udrf, bus.zer, bus.inf, bus.nan}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000, 28);
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
        wait_done();
        issue(32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'b00000, 28); wait_done();
        issue(32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 5'b00000, 28); wait_done();
        issue(32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'b00000, 28); wait_done();
        issue(32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 5'b00000, 28); wait_done();
        issue(32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 5'b00000, 28); wait_done();
        issue(32'h3F800000, 32'h40400000, 3'd6, 32'h3EAAAAAB, 5'b00000, 28); wait_done();
        issue(32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'b00010, 1);  wait_done();
        issue(32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b00001, 1);  wait_done();
        issue(32'h00400000, 32'h3F800000, 3'd0, 32'h00000000, 5'b00100, 1);  wait_done();
        issue(32'h7F000000, 32'h00800000, 3'd0, 32'h7F800000, 5'b10010, 28); wait_done();
        issue(32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 5'b01100, 28); wait_done();

        // start while busy with different operands must be ignored
        issue(32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'b00000, 28);
        repeat (5) @(posedge clk);
        #1;
        bus.fp_X  = 32'h40C00000;
        bus.fp_Y  = 32'h00000000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_ignores_start", {31'd0, bus.busy}, 32'd1);
        wait_done();

        // reset in the middle of CALC
        issue_model(32'h40490FDB, 32'h402DF854, 3'd0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_fp_Z", bus.fp_Z, 32'd0);
        check("midreset_done_busy", {30'd0, bus.done, bus.busy}, 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("after_reset_idle", {30'd0, bus.done, bus.busy}, 32'd0);
        issue_model(32'h40490FDB, 32'h402DF854, 3'd0);
        wait_done();

        for (int i = 0; i < 80; i++) begin
            x = rand_operand();
            y = rand_operand();
            if ($urandom_range(0, 7) == 0) y[22:0] = x[22:0];
            issue_model(x, y, 3'($urandom_range(0, 7)));
            wait_done();
        end

        @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
